// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline-stage register.
//   CTRL_W            default control-vector width
//   CTRL_*            bit positions of control bits that must never fire from a bubble
//   DEFAULT_KILL_MASK control bits forced to zero while the stage is empty
//   state_t           occupancy state; the encoding equals the entry count
package pipe_stage_skid_pkg;

  localparam int CTRL_W       = 24;
  localparam int CTRL_REGWEN  = 1;
  localparam int CTRL_MEMW    = 2;
  localparam int CTRL_MEMREAD = 3;

  localparam logic [CTRL_W-1:0] DEFAULT_KILL_MASK =
    (CTRL_W'(1) << CTRL_REGWEN) | (CTRL_W'(1) << CTRL_MEMW) | (CTRL_W'(1) << CTRL_MEMREAD);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying payload, control vector and hold tag.
//   valid  producer has an entry
//   ready  consumer accepts the entry this cycle
//   data   opaque payload
//   ctrl   control vector
//   hold   multi-cycle entry tag
// master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = 24
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  logic              hold;

  modport master (output valid, output data, output ctrl, output hold, input ready);
  modport slave  (input valid, input data, input ctrl, input hold, output ready);
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// One stored entry {valid, hold, ctrl, data}.
//   clk, reset     clock and synchronous active-high reset (clears everything)
//   load           capture d_* and mark the entry valid
//   clear          drop the entry; payload and ctrl keep their last value
//   d_hold/ctrl/data  value captured on load
//   valid/hold/ctrl/data  stored entry
module pipe_stage_skid_entry_reg #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              d_hold,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic              hold,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // load wins over clear so a same-cycle pop/push keeps the new entry
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      hold  <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      hold  <= d_hold;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (clear) begin
      valid <= 1'b0;
      hold  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and optional two-entry skid buffer.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   flush  discard all held entries; a same-cycle input entry is dropped
//   up     upstream handshake (slave): valid/data/ctrl/hold in, ready out
//   dn     downstream handshake (master): head entry out, ready in
//   count  occupancy 0..2
// SKID=1: ready toward upstream is a flop, so there is no combinational path
// from dn.ready to up.ready; a second entry parks in the skid register.
// SKID=0: single entry, up.ready = !dn.valid | dn.ready.
module pipe_stage_skid #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = pipe_stage_skid_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(pipe_stage_skid_pkg::DEFAULT_KILL_MASK),
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic [1:0]        count
);
  import pipe_stage_skid_pkg::*;

  state_t            state, state_nxt;
  logic              in_xfer, out_xfer, in_ready_int;
  logic              head_load, head_clear;
  logic              head_src_hold;
  logic [CTRL_W-1:0] head_src_ctrl;
  logic [DATA_W-1:0] head_src_data;
  logic              head_valid, head_hold;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  // Empty stage must not assert side-effecting control bits.
  function automatic logic [CTRL_W-1:0] bubble_ctrl(input logic [CTRL_W-1:0] ctrl,
                                                    input logic valid);
    return valid ? ctrl : (ctrl & ~KILL_MASK);
  endfunction

  assign in_xfer  = up.valid & in_ready_int;
  assign out_xfer = head_valid & dn.ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer && SKID != 0) state_nxt = ST_FULL;
          else if (!in_xfer && out_xfer)         state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_xfer) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_stage_skid_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk    (clk),
    .reset  (reset),
    .load   (head_load),
    .clear  (head_clear),
    .d_hold (head_src_hold),
    .d_ctrl (head_src_ctrl),
    .d_data (head_src_data),
    .valid  (head_valid),
    .hold   (head_hold),
    .ctrl   (head_ctrl),
    .data   (head_data)
  );

  if (SKID != 0) begin : g_skid
    logic              skid_valid, skid_hold, skid_load, skid_clear, in_ready_q;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_stage_skid_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_hold (up.hold),
      .d_ctrl (up.ctrl),
      .d_data (up.data),
      .valid  (skid_valid),
      .hold   (skid_hold),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );

    always_comb begin
      head_load     = 1'b0;
      head_clear    = flush;
      skid_load     = 1'b0;
      skid_clear    = flush;
      head_src_hold = up.hold;
      head_src_ctrl = up.ctrl;
      head_src_data = up.data;
      if (!flush) begin
        case (state)
          ST_EMPTY: head_load = in_xfer;
          ST_ONE: begin
            head_load  = in_xfer & out_xfer;
            head_clear = out_xfer & ~in_xfer;
            skid_load  = in_xfer & ~out_xfer;
          end
          ST_FULL: begin
            // skid entry advances to the head
            head_load     = out_xfer & skid_valid;
            skid_clear    = out_xfer;
            head_src_hold = skid_hold;
            head_src_ctrl = skid_ctrl;
            head_src_data = skid_data;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) in_ready_q <= 1'b1;
      else       in_ready_q <= (state_nxt != ST_FULL);
    end

    assign in_ready_int = in_ready_q;
  end else begin : g_single
    assign in_ready_int  = ~head_valid | dn.ready;
    assign head_load     = ~flush & in_xfer;
    assign head_clear    = flush | (out_xfer & ~in_xfer);
    assign head_src_hold = up.hold;
    assign head_src_ctrl = up.ctrl;
    assign head_src_data = up.data;
  end

  always_comb begin
    dn.valid = head_valid;
    dn.hold  = head_valid & head_hold;
    dn.ctrl  = bubble_ctrl(head_ctrl, head_valid);
    dn.data  = head_data;
    up.ready = in_ready_int;
    count    = state;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DW = 192;
  localparam int CW = 24;
  localparam logic [CW-1:0] MASK = 24'h00000E;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          hold;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] count;
  int checks = 0;
  int failures = 0;

  // reference: a FIFO of depth 2 plus the ctrl of the most recent head entry
  ent_t          q[$];
  logic [CW-1:0] last_ctrl = '0;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(MASK), .SKID(1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one clock and update the reference from the pre-edge inputs.
  task automatic tick();
    bit   do_in, do_out;
    ent_t e;
    do_in  = up_if.valid && (q.size() < 2);
    do_out = (q.size() > 0) && dn_if.ready;
    e.data = up_if.data;
    e.ctrl = up_if.ctrl;
    e.hold = up_if.hold;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      last_ctrl = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back(e);
    end
    if (q.size() > 0) last_ctrl = q[0].ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    up_if.valid = 1'b1;
    up_if.data = rand_data();
    up_if.ctrl = 24'hFFFFFF;
    up_if.hold = 1'b1;
    dn_if.ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    up_if.valid = 1'b0;
    checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", dn_if.valid); end
    checks++; if (dn_if.ctrl !== 24'h0) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=000000", dn_if.ctrl); end
    checks++; if (dn_if.data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", dn_if.data); end
    checks++; if (dn_if.hold !== 1'b0) begin failures++; $display("FAIL reset_out_hold got=%0b exp=0", dn_if.hold); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (up_if.ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", up_if.ready); end
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    up_if.hold = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      up_if.valid = 1'b1;
      up_if.data = DW'(i);
      up_if.ctrl = CW'($urandom());
      tick();
      checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(i)) begin failures++; $display("FAIL stream_data[%0d] got valid=%0b data=%0d exp valid=1 data=%0d", i, dn_if.valid, dn_if.data, i); end
      checks++; if (count !== 2'd1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
      checks++; if (up_if.ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, up_if.ready); end
    end
    up_if.valid = 1'b0;
    tick();
    checks++; if (dn_if.valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL stream_drain got valid=%0b count=%0d exp valid=0 count=0", dn_if.valid, count); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    logic [DW-1:0] got[$];
    bit c_done;
    a = rand_data(); b = rand_data(); c = rand_data();
    c_done = 0;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data = a;
    tick();
    up_if.data = b;
    tick();
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL bp_count_after_b got=%0d exp=2", count); end
    checks++; if (up_if.ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%0b exp=0", up_if.ready); end
    up_if.data = c;
    tick();
    checks++; if (count !== 2'd2 || dn_if.data !== a) begin failures++; $display("FAIL bp_c_rejected got count=%0d head=%h exp count=2 head=%h", count, dn_if.data, a); end
    dn_if.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (dn_if.valid) got.push_back(dn_if.data);
      if (up_if.valid && up_if.ready) c_done = 1;
      tick();
      if (c_done) up_if.valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin failures++; $display("FAIL bp_out_count got=%0d exp=3", got.size()); end
    else begin
      checks++; if (got[0] !== a || got[1] !== b || got[2] !== c) begin failures++; $display("FAIL bp_order got=%h,%h,%h exp=%h,%h,%h", got[0][31:0], got[1][31:0], got[2][31:0], a[31:0], b[31:0], c[31:0]); end
    end
  endtask

  task automatic test_bubble_kill();
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    up_if.ctrl = 24'hFFFFFF;
    up_if.data = rand_data();
    up_if.hold = 1'b1;
    tick();
    checks++; if (dn_if.ctrl !== 24'hFFFFFF || dn_if.hold !== 1'b1) begin failures++; $display("FAIL kill_live got ctrl=%h hold=%0b exp ctrl=ffffff hold=1", dn_if.ctrl, dn_if.hold); end
    up_if.valid = 1'b0;
    up_if.hold = 1'b0;
    tick();
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL kill_valid got=%0b exp=0", dn_if.valid); end
    checks++; if (dn_if.ctrl !== 24'hFFFFF1) begin failures++; $display("FAIL kill_ctrl got=%h exp=fffff1", dn_if.ctrl); end
    checks++; if (dn_if.hold !== 1'b0) begin failures++; $display("FAIL kill_hold got=%0b exp=0", dn_if.hold); end
  endtask

  task automatic test_hold_stall();
    logic [DW-1:0] d;
    logic [CW-1:0] dc;
    d = rand_data();
    dc = CW'($urandom());
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.hold = 1'b1;
    up_if.data = d;
    up_if.ctrl = dc;
    tick();
    up_if.valid = 1'b0;
    up_if.hold = 1'b0;
    up_if.data = rand_data();
    up_if.ctrl = CW'($urandom());
    for (int k = 0; k < 5; k++) begin
      checks++; if (dn_if.valid !== 1'b1 || dn_if.hold !== 1'b1) begin failures++; $display("FAIL stall_tag[%0d] got valid=%0b hold=%0b exp 1 1", k, dn_if.valid, dn_if.hold); end
      checks++; if (dn_if.ctrl !== dc || dn_if.data !== d) begin failures++; $display("FAIL stall_entry[%0d] got ctrl=%h data=%h exp ctrl=%h data=%h", k, dn_if.ctrl, dn_if.data[31:0], dc, d[31:0]); end
      tick();
    end
    dn_if.ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data = rand_data();
    tick();
    up_if.data = rand_data();
    tick();
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_prefill got=%0d exp=2", count); end
    up_if.data = rand_data();
    up_if.hold = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    up_if.valid = 1'b0;
    up_if.hold = 1'b0;
    checks++; if (count !== 2'd0 || dn_if.valid !== 1'b0) begin failures++; $display("FAIL flush_empty got count=%0d valid=%0b exp 0 0", count, dn_if.valid); end
    checks++; if (up_if.ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", up_if.ready); end
    dn_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (dn_if.valid !== 1'b0) begin failures++; $display("FAIL flush_e_leaked[%0d] got valid=%0b exp=0", k, dn_if.valid); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      up_if.data  = rand_data();
      up_if.ctrl  = CW'($urandom());
      up_if.hold  = 1'($urandom_range(0, 1));
      dn_if.ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (count !== 2'(q.size()) || dn_if.valid !== (q.size() > 0) || up_if.ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_occ[%0d] got count=%0d valid=%0b ready=%0b exp count=%0d", n, count, dn_if.valid, up_if.ready, q.size()); end
      if (q.size() > 0) begin
        checks++; if (dn_if.data !== q[0].data || dn_if.ctrl !== q[0].ctrl || dn_if.hold !== q[0].hold) begin failures++; $display("FAIL rand_head[%0d] got ctrl=%h hold=%0b data=%h exp ctrl=%h hold=%0b data=%h", n, dn_if.ctrl, dn_if.hold, dn_if.data[31:0], q[0].ctrl, q[0].hold, q[0].data[31:0]); end
      end else begin
        checks++; if (dn_if.ctrl !== (last_ctrl & ~MASK) || dn_if.hold !== 1'b0) begin failures++; $display("FAIL rand_bubble[%0d] got ctrl=%h hold=%0b exp ctrl=%h hold=0", n, dn_if.ctrl, dn_if.hold, last_ctrl & ~MASK); end
      end
    end
    reset = 1'b0;
    flush = 1'b0;
    up_if.valid = 1'b0;
    tick();
  endtask

  initial begin
    up_if.valid = 1'b0;
    up_if.data = '0;
    up_if.ctrl = '0;
    up_if.hold = 1'b0;
    dn_if.ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble_kill();
    test_hold_stall();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
